cpu_trace_monitor: RTL and testbench

Synthesizable, parametrised retire-stream monitor for the 16-bit CPU core, and the hardware successor to the simulation-only bench checker.
- Counts cycles and retired instructions.
- Detects halt (JMP-to-self, i.e. repeated PC) and a watchdog timeout.
- Keeps a circular trace of the last TRACE_DEPTH retired {PC, instruction} pairs, drained afterwards over a valid/ready port.
- Sits beside the core, fed from its retire point; drives status to the debug/LED logic and the bench.

---
 rtl/cpu_trace_pkg.sv | 40 ++++
 rtl/cpu_trace_monitor_ring.sv | 62 ++++++
 rtl/cpu_trace_monitor.sv | 175 +++++++++++++++++
 tb/tb_cpu_trace_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU retire-stream monitor.
//   state_e   : monitor FSM states (encoding is visible on the state port)
//   opcode_e  : 4-bit opcode field values 0..7; anything above 7 is unknown
//   sat_inc   : saturating increment for counters up to SAT_W bits wide
package cpu_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_LW  = 4'd4,
    OP_SW  = 4'd5,
    OP_BEQ = 4'd6,
    OP_JMP = 4'd7
  } opcode_e;

  localparam int OPC_W   = 4;
  localparam int NUM_OPC = 8;
  localparam int SAT_W   = 64;

  // Increment val, holding at the all-ones value of a width-bit counter.
  // Callers zero-extend into SAT_W bits and truncate the result back.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                              input int unsigned     width);
    logic [SAT_W-1:0] max_val;
    if (width >= SAT_W) max_val = '1;
    else                max_val = (SAT_W'(1) << width) - SAT_W'(1);
    if (val >= max_val) return max_val;
    else                return val + SAT_W'(1);
  endfunction

endpackage

// File: rtl/cpu_trace_monitor_ring.sv
// Circular trace store: keeps the most recent DEPTH entries.
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous wipe of pointers, count and storage
//   push        : write push_data; when full the oldest entry is overwritten
//   pop         : drop the head entry (ignored when empty)
//   head_data   : oldest entry, combinational from storage
//   empty       : no entries held
// DEPTH must be a power of two so pointers wrap naturally.
module trace_ring_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_BW = PTR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_BW-1:0] count;
  logic              full;
  logic              pop_fire;

  assign empty     = (count == '0);
  assign full      = (count == CNT_BW'(DEPTH));
  assign pop_fire  = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      // A push into a full ring drags the read pointer along with it, so the
      // head always stays the oldest surviving entry.
      if (pop_fire || (push && full)) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop_fire && !full)  count <= count + CNT_BW'(1);
      else if (pop_fire && !push)      count <= count - CNT_BW'(1);
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Retire-stream monitor for the 16-bit CPU core.
// Counts RUN cycles and retires, detects halt (same PC retired HALT_REPEAT
// times in a row) and watchdog timeout, and keeps a trace of the last
// TRACE_DEPTH {pc, instr} pairs that can be drained once RUN has ended.
// Build option: define OPCODE_HIST_EN to add per-opcode retire counters;
// without it hist_flat is tied to zero.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : IDLE -> RUN
//   clear                : back to IDLE, wipe counters and trace
//   retire_valid/pc/instr: retire stream from the core
//   rd_valid/ready/data  : trace drain, oldest first, {pc, instr}
//   state                : IDLE=0 RUN=1 HALTED=2 TIMEOUT=3
//   cycle_count          : cycles spent in RUN
//   instr_count          : retires accepted in RUN
//   unknown_count        : retires with opcode > 7
//   hist_flat            : opcode k count at [k*CNT_W +: CNT_W]
//
// state   | meaning
// IDLE    | waiting for start; counters and trace empty
// RUN     | counting and tracing retires
// HALTED  | halt seen; everything frozen, trace drainable
// TIMEOUT | watchdog expired; everything frozen, trace drainable
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int PC_W           = 16,
  parameter int INSTR_W        = 16,
  parameter int TRACE_DEPTH    = 16,
  parameter int HALT_REPEAT    = 2,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int CNT_W          = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    retire_valid,
  input  logic [PC_W-1:0]         retire_pc,
  input  logic [INSTR_W-1:0]      retire_instr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [PC_W+INSTR_W-1:0] rd_data,
  output logic [1:0]              state,
  output logic [CNT_W-1:0]        cycle_count,
  output logic [CNT_W-1:0]        instr_count,
  output logic [CNT_W-1:0]        unknown_count,
  output logic [8*CNT_W-1:0]      hist_flat
);

  localparam int REP_W = $clog2(HALT_REPEAT + 1);

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(SAT_W'(v), CNT_W));
  endfunction

  state_e             state_q;
  logic [REP_W-1:0]   rep_q;
  logic [REP_W-1:0]   rep_next;
  logic [PC_W-1:0]    last_pc_q;
  logic [CNT_W-1:0]   cycle_q;
  logic [CNT_W-1:0]   instr_q;
  logic [CNT_W-1:0]   unknown_q;
  logic [OPC_W-1:0]   opcode;
  logic               opc_unknown;
  logic               in_run;
  logic               accept;
  logic               halt_hit;
  logic               timeout_hit;
  logic               ring_empty;

  assign opcode      = retire_instr[INSTR_W-1 -: OPC_W];
  assign opc_unknown = (opcode > OPC_W'(OP_JMP));
  assign in_run      = (state_q == RUN);
  assign accept      = in_run && retire_valid && !clear;

  // rep_q == 0 marks "no retire yet this run", so the first retire always
  // restarts the streak even if its PC matches a stale last_pc_q.
  always_comb begin
    rep_next = REP_W'(1);
    if (rep_q != '0 && retire_pc == last_pc_q && rep_q != REP_W'(HALT_REPEAT))
      rep_next = rep_q + REP_W'(1);
  end

  assign halt_hit    = accept && (rep_next == REP_W'(HALT_REPEAT));
  assign timeout_hit = in_run && (cycle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rep_q     <= '0;
      last_pc_q <= '0;
    end else if (clear) begin
      state_q   <= IDLE;
      rep_q     <= '0;
      last_pc_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rep_q <= '0;
          if (start) state_q <= RUN;
        end
        RUN: begin
          if (accept) begin
            rep_q     <= rep_next;
            last_pc_q <= retire_pc;
          end
          // Halt outranks a timeout landing on the same cycle.
          if (halt_hit)         state_q <= HALTED;
          else if (timeout_hit) state_q <= TIMEOUT;
        end
        default: state_q <= state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      instr_q   <= '0;
      unknown_q <= '0;
    end else if (clear) begin
      cycle_q   <= '0;
      instr_q   <= '0;
      unknown_q <= '0;
    end else if (in_run) begin
      cycle_q <= cnt_inc(cycle_q);
      if (retire_valid) begin
        instr_q <= cnt_inc(instr_q);
        if (opc_unknown) unknown_q <= cnt_inc(unknown_q);
      end
    end
  end

  trace_ring_buffer #(
    .WIDTH (PC_W + INSTR_W),
    .DEPTH (TRACE_DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .push      (accept),
    .push_data ({retire_pc, retire_instr}),
    .pop       (rd_valid && rd_ready),
    .head_data (rd_data),
    .empty     (ring_empty)
  );

  assign rd_valid      = !in_run && !ring_empty;
  assign state         = state_q;
  assign cycle_count   = cycle_q;
  assign instr_count   = instr_q;
  assign unknown_count = unknown_q;

`ifdef OPCODE_HIST_EN
  logic [CNT_W-1:0] hist_q [NUM_OPC];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_OPC; k++) hist_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_OPC; k++) hist_q[k] <= '0;
    end else if (accept && !opc_unknown) begin
      hist_q[opcode[2:0]] <= cnt_inc(hist_q[opcode[2:0]]);
    end
  end

  for (genvar k = 0; k < NUM_OPC; k++) begin : g_hist
    assign hist_flat[k*CNT_W +: CNT_W] = hist_q[k];
  end
`else
  assign hist_flat = '0;
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
module tb_cpu_trace_monitor;

  localparam int PC_W = 16;
  localparam int INSTR_W = 16;
  localparam int DEPTH = 16;
  localparam int HALT_REP = 2;
  localparam int TMO = 100;
  localparam int CW = 32;

  localparam int S_IDLE = 0, S_RUN = 1, S_HALTED = 2, S_TIMEOUT = 3;

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0, clear = 0, retire_valid = 0, rd_ready = 0;
  logic [PC_W-1:0] retire_pc = '0;
  logic [INSTR_W-1:0] retire_instr = '0;
  logic rd_valid;
  logic [PC_W+INSTR_W-1:0] rd_data;
  logic [1:0] state;
  logic [CW-1:0] cycle_count, instr_count, unknown_count;
  logic [8*CW-1:0] hist_flat;

  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  cpu_trace_monitor #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .TRACE_DEPTH(DEPTH),
    .HALT_REPEAT(HALT_REP), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .state(state), .cycle_count(cycle_count), .instr_count(instr_count),
    .unknown_count(unknown_count), .hist_flat(hist_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            m_state = S_IDLE;
  logic [CW-1:0] m_cycle = '0, m_instr = '0, m_unk = '0;
  logic [CW-1:0] m_hist [8] = '{default: '0};
  logic [31:0]   m_q [$];
  int            m_streak = 0;
  logic [PC_W-1:0] m_last = '0;

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1;
  endfunction

  task automatic m_reset();
    m_state = S_IDLE;
    m_cycle = '0; m_instr = '0; m_unk = '0;
    for (int k = 0; k < 8; k++) m_hist[k] = '0;
    m_q.delete();
    m_streak = 0;
  endtask

  task automatic m_step();
    bit halt, tmo, pop_ok;
    int op;
    pop_ok = (m_state != S_RUN) && (m_q.size() != 0) && rd_ready;
    if (clear) begin
      m_reset();
      return;
    end
    if (pop_ok) void'(m_q.pop_front());
    case (m_state)
      S_IDLE: if (start) begin m_state = S_RUN; m_streak = 0; end
      S_RUN: begin
        halt = 0;
        tmo = (m_cycle == TMO - 1);
        m_cycle = sat(m_cycle);
        if (retire_valid) begin
          op = int'(retire_instr[15:12]);
          m_instr = sat(m_instr);
          if (op > 7) m_unk = sat(m_unk);
`ifdef OPCODE_HIST_EN
          else m_hist[op] = sat(m_hist[op]);
`endif
          m_q.push_back({retire_pc, retire_instr});
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          if (m_streak > 0 && retire_pc == m_last) m_streak++;
          else m_streak = 1;
          m_last = retire_pc;
          if (m_streak >= HALT_REP) halt = 1;
        end
        if (halt) m_state = S_HALTED;
        else if (tmo) m_state = S_TIMEOUT;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else m_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", 64'(state), 64'(m_state));
      chk("cycle_count", 64'(cycle_count), 64'(m_cycle));
      chk("instr_count", 64'(instr_count), 64'(m_instr));
      chk("unknown_count", 64'(unknown_count), 64'(m_unk));
      chk("rd_valid", 64'(rd_valid), 64'((m_state != S_RUN) && (m_q.size() != 0)));
      if ((m_state != S_RUN) && (m_q.size() != 0))
        chk("rd_data", 64'(rd_data), 64'(m_q[0]));
      for (int k = 0; k < 8; k++)
        chk("hist", 64'(hist_flat[k*CW +: CW]), 64'(m_hist[k]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1; tick(); start = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] instr);
    retire_valid = 1; retire_pc = pc; retire_instr = instr;
    tick();
    retire_valid = 0;
  endtask

  logic [15:0] got_pc [$];

  task automatic drain();
    got_pc.delete();
    rd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      if (!rd_valid) break;
      got_pc.push_back(rd_data[31:16]);
      tick();
    end
    rd_ready = 0;
  endtask

  initial begin
    logic [15:0] exp1 [5];
    exp1 = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3};

    #1;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    tick(); tick();
    rst_n = 1;
    cmp_en = 1;
    tick();

    // 1: halt on repeated PC
    do_start();
    for (int i = 0; i < 5; i++) retire(exp1[i], 16'h1000 | exp1[i]);
    chk("t1_state", 64'(state), 64'd2);
    chk("t1_instr", 64'(instr_count), 64'd5);
    drain();
    chk("t1_drain_n", 64'(got_pc.size()), 64'd5);
    for (int i = 0; i < 5 && i < got_pc.size(); i++)
      chk("t1_drain_pc", 64'(got_pc[i]), 64'(exp1[i]));
    chk("t1_empty", 64'(rd_valid), 64'd0);
    do_clear();

    // 2: timeout with trace overflow
    do_start();
    for (int i = 0; i < 20; i++) retire(16'(i), 16'h2000);
    for (int i = 0; i < 200 && state == 2'd1; i++) tick();
    chk("t2_state", 64'(state), 64'd3);
    chk("t2_cycles", 64'(cycle_count), 64'd100);
    chk("t2_instr", 64'(instr_count), 64'd20);
    drain();
    chk("t2_drain_n", 64'(got_pc.size()), 64'd16);
    for (int i = 0; i < 16 && i < got_pc.size(); i++)
      chk("t2_drain_pc", 64'(got_pc[i]), 64'(i + 4));
    do_clear();

    // 3: halt and timeout on the same cycle
    do_start();
    for (int i = 0; i < 98; i++) tick();
    retire(16'd7, 16'h7007);
    retire(16'd7, 16'h7007);
    chk("t3_state", 64'(state), 64'd2);
    chk("t3_cycles", 64'(cycle_count), 64'd100);
    do_clear();

    // 4: partial drain then clear with a concurrent handshake
    do_start();
    retire(16'd10, 16'h3000);
    retire(16'd11, 16'h4000);
    retire(16'd11, 16'h4000);
    chk("t4_state", 64'(state), 64'd2);
    rd_ready = 1; tick(); rd_ready = 0;
    chk("t4_head_pc", 64'(rd_data[31:16]), 64'd11);
    clear = 1; rd_ready = 1; tick(); clear = 0; rd_ready = 0;
    chk("t4_idle", 64'(state), 64'd0);
    chk("t4_cycles", 64'(cycle_count), 64'd0);
    chk("t4_rd_valid", 64'(rd_valid), 64'd0);

    // 5: async reset mid-run
    do_start();
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) retire(16'(100 + i), 16'h5000);
      else tick();
    end
    #2 rst_n = 0;
    #1;
    chk("t5_state", 64'(state), 64'd0);
    chk("t5_cycles", 64'(cycle_count), 64'd0);
    chk("t5_instr", 64'(instr_count), 64'd0);
    chk("t5_rd_valid", 64'(rd_valid), 64'd0);
    chk("t5_rd_data", 64'(rd_data), 64'd0);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) retire(16'(50 + i), 16'h0000);
    chk("t5_ignored", 64'(instr_count), 64'd0);
    chk("t5_still_idle", 64'(state), 64'd0);
    do_clear();

    // 6: opcode histogram and unknown count
    do_start();
    retire(16'd1, 16'h0123);
    retire(16'd2, 16'h6000);
    retire(16'd3, 16'h6000);
    retire(16'd4, 16'hF000);
    chk("t6_unknown", 64'(unknown_count), 64'd1);
`ifdef OPCODE_HIST_EN
    chk("t6_hist_add", 64'(hist_flat[0*CW +: CW]), 64'd1);
    chk("t6_hist_beq", 64'(hist_flat[6*CW +: CW]), 64'd2);
    chk("t6_hist_jmp", 64'(hist_flat[7*CW +: CW]), 64'd0);
`else
    chk("t6_hist_low", 64'(hist_flat[63:0]), 64'd0);
    chk("t6_hist_beq", 64'(hist_flat[6*CW +: CW]), 64'd0);
`endif
    do_clear();
    tick();

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
